// File: rtl/issue_queue.sv
// In-order issue queue: DEPTH-entry micro-op buffer with a pending-write scoreboard feeding NUM_UNITS units.
// Latency: accept at edge E0, issue at E1, ex_valid high the cycle after E1 (minimum 2 edges).
// Backpressure: in_ready = count < DEPTH (registered only); a blocked head stalls everything behind it.
module issue_queue #(
  parameter int DEPTH     = 4,
  parameter int NUM_REGS  = 32,
  parameter int NUM_UNITS = 3,
  parameter int DATA_W    = 32,
  parameter int UOP_W     = 48,
  localparam int RAW      = $clog2(NUM_REGS),
  localparam int UW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [UOP_W-1:0]     in_uop,
  input  logic [UW-1:0]        in_unit,
  input  logic [RAW-1:0]       in_addra,
  input  logic [RAW-1:0]       in_addrb,
  input  logic                 in_check_a,
  input  logic                 in_check_b,
  input  logic [RAW-1:0]       in_dest,
  input  logic                 in_writereg,
  output logic [RAW-1:0]       rf_addra,
  output logic [RAW-1:0]       rf_addrb,
  input  logic [DATA_W-1:0]    rf_dataa,
  input  logic [DATA_W-1:0]    rf_datab,
  input  logic [NUM_UNITS-1:0] unit_busy,
  input  logic                 wb_valid,
  input  logic [RAW-1:0]       wb_addr,
  input  logic                 flush,
  output logic [NUM_UNITS-1:0] ex_valid,
  output logic [UOP_W-1:0]     ex_uop,
  output logic [DATA_W-1:0]    ex_rega,
  output logic [DATA_W-1:0]    ex_regb,
  output logic [RAW-1:0]       ex_dest,
  output logic                 ex_writereg,
  output logic                 iss_stall,
  output logic [CW-1:0]        count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic [UW-1:0]    unit;
    logic [RAW-1:0]   addra;
    logic [RAW-1:0]   addrb;
    logic             check_a;
    logic             check_b;
    logic [RAW-1:0]   dest;
    logic             writereg;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               head;
  entry_t               enq_entry;

  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NUM_REGS-1:0]  pending_q, pending_d;

  logic [NUM_UNITS-1:0] ex_valid_q, ex_valid_d;
  logic [UOP_W-1:0]     ex_uop_q;
  logic [DATA_W-1:0]    ex_rega_q;
  logic [DATA_W-1:0]    ex_regb_q;
  logic [RAW-1:0]       ex_dest_q;
  logic                 ex_writereg_q;

  logic                 head_valid;
  logic                 raw_hz;
  logic                 waw_hz;
  logic                 unit_blk;
  logic [NUM_UNITS-1:0] unit_onehot;
  logic                 do_enq;
  logic                 do_write;
  logic                 do_issue;

  assign head       = mem_q[head_q];
  assign head_valid = (count_q != '0);
  assign in_ready   = (count_q < CW'(DEPTH));
  assign do_enq     = in_valid && in_ready;
  assign do_write   = do_enq && !flush;

  assign enq_entry = '{uop: in_uop, unit: in_unit, addra: in_addra, addrb: in_addrb,
                       check_a: in_check_a, check_b: in_check_b, dest: in_dest,
                       writereg: in_writereg};

  // Hazards look only at registered pending bits, so a same-cycle writeback never unblocks the head.
  assign raw_hz = (head.check_a && pending_q[head.addra]) ||
                  (head.check_b && pending_q[head.addrb]);
  assign waw_hz = head.writereg && pending_q[head.dest];

  // Decode the head's unit index into a busy lookup and a one-hot strobe; out-of-range indices map to nothing.
  always_comb begin
    unit_blk    = 1'b0;
    unit_onehot = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (head.unit == UW'(u)) begin
        unit_blk       = unit_blk | unit_busy[u];
        unit_onehot[u] = 1'b1;
      end
    end
  end

  assign iss_stall = head_valid && (raw_hz || waw_hz || unit_blk);
  assign do_issue  = head_valid && !iss_stall && !flush;

  assign rf_addra = head.addra;
  assign rf_addrb = head.addrb;

  // Next-state for pointers, occupancy, scoreboard and the execute strobe.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    pending_d  = pending_q;
    ex_valid_d = '0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_enq) begin
        tail_d = tail_q + 1'b1;
      end
      if (do_issue) begin
        head_d     = head_q + 1'b1;
        ex_valid_d = unit_onehot;
      end
      count_d = count_q + CW'(do_enq) - CW'(do_issue);
    end
    // Writeback clears first so an issue to the same register in the same cycle wins.
    if (wb_valid) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (do_issue && head.writereg) begin
      pending_d[head.dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_q[tail_q] <= enq_entry;
    end
  end

  // Control state and the registered execute-stage outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      pending_q     <= '0;
      ex_valid_q    <= '0;
      ex_uop_q      <= '0;
      ex_rega_q     <= '0;
      ex_regb_q     <= '0;
      ex_dest_q     <= '0;
      ex_writereg_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      ex_valid_q <= ex_valid_d;
      if (do_issue) begin
        ex_uop_q      <= head.uop;
        ex_rega_q     <= rf_dataa;
        ex_regb_q     <= rf_datab;
        ex_dest_q     <= head.dest;
        ex_writereg_q <= head.writereg;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_uop      = ex_uop_q;
  assign ex_rega     = ex_rega_q;
  assign ex_regb     = ex_regb_q;
  assign ex_dest     = ex_dest_q;
  assign ex_writereg = ex_writereg_q;
  assign count       = count_q;

endmodule
